// File: rtl/cv32e40p_fpu_share_arb.sv
// Round-robin issue arbiter sharing one FPU between NB_REQ requesters.
// An in-order tag FIFO routes each FPU result back to the requester that issued it.
module cv32e40p_fpu_share_arb #(
    parameter int unsigned NB_REQ = 2,
    parameter int unsigned PLD_W  = 110,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NB_REQ-1:0]       req_i,
    input  logic [NB_REQ*PLD_W-1:0] pld_i,
    output logic [NB_REQ-1:0]       gnt_o,
    output logic [NB_REQ-1:0]       rvalid_o,
    output logic [31:0]             result_o,
    output logic [4:0]              flags_o,
    output logic                    fpu_req_o,
    output logic [PLD_W-1:0]        fpu_pld_o,
    input  logic                    fpu_gnt_i,
    input  logic                    fpu_rvalid_i,
    input  logic [31:0]             fpu_result_i,
    input  logic [4:0]              fpu_flags_i,
    output logic                    busy_o,
    output logic                    err_o
);

    localparam int unsigned ID_W  = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic             err_q;
    logic [ID_W-1:0]  tag_mem_q [DEPTH];

    logic [ID_W-1:0]  win;
    logic [ID_W-1:0]  head;
    logic             full, fire, pop;

    // Scan from rr_ptr upwards; first active request wins.
    always_comb begin
        int unsigned idx;
        logic        found;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 0; i < NB_REQ; i++) begin
            idx = (32'(rr_ptr_q) + i) % NB_REQ;
            if (!found && req_i[idx]) begin
                win   = ID_W'(idx);
                found = 1'b1;
            end
        end
    end

    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign fpu_req_o = (|req_i) & ~full;
    assign fire      = fpu_req_o & fpu_gnt_i;
    assign fpu_pld_o = pld_i[32'(win)*PLD_W +: PLD_W];

    assign head = tag_mem_q[rd_ptr_q];
    assign pop  = fpu_rvalid_i && (cnt_q != '0);

    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        for (int unsigned k = 0; k < NB_REQ; k++) begin
            gnt_o[k]    = fire && (win == ID_W'(k));
            rvalid_o[k] = pop && (head == ID_W'(k));
        end
    end

    assign rr_ptr_d = (win == ID_W'(NB_REQ - 1)) ? '0 : win + 1'b1;
    assign wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    assign rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (fire) begin
                rr_ptr_q <= rr_ptr_d;
                wr_ptr_q <= wr_ptr_d;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_d;
            end
            if (fire && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!fire && pop) begin
                cnt_q <= cnt_q - 1'b1;
            end
            // A result with nothing in flight means the FPU and arbiter lost sync.
            if (fpu_rvalid_i && (cnt_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (fire) begin
            tag_mem_q[wr_ptr_q] <= win;
        end
    end

    assign result_o = fpu_result_i;
    assign flags_o  = fpu_flags_i;
    assign busy_o   = (cnt_q != '0);
    assign err_o    = err_q;

endmodule

// File: tb/tb_cv32e40p_fpu_share_arb.sv
// Directed bench for cv32e40p_fpu_share_arb with NB_REQ=2, DEPTH=4.
module tb_cv32e40p_fpu_share_arb;

    localparam int unsigned NB_REQ = 2;
    localparam int unsigned PLD_W  = 110;
    localparam int unsigned DEPTH  = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NB_REQ-1:0]       req;
    logic [NB_REQ*PLD_W-1:0] pld;
    logic [NB_REQ-1:0]       gnt;
    logic [NB_REQ-1:0]       rvalid;
    logic [31:0]             result;
    logic [4:0]              flags;
    logic                    fpu_req;
    logic [PLD_W-1:0]        fpu_pld;
    logic                    fpu_gnt;
    logic                    fpu_rvalid;
    logic [31:0]             fpu_result;
    logic [4:0]              fpu_flags;
    logic                    busy;
    logic                    err;

    int checks   = 0;
    int failures = 0;

    logic [PLD_W-1:0] p0, p1;

    cv32e40p_fpu_share_arb #(
        .NB_REQ(NB_REQ),
        .PLD_W (PLD_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .pld_i       (pld),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .result_o    (result),
        .flags_o     (flags),
        .fpu_req_o   (fpu_req),
        .fpu_pld_o   (fpu_pld),
        .fpu_gnt_i   (fpu_gnt),
        .fpu_rvalid_i(fpu_rvalid),
        .fpu_result_i(fpu_result),
        .fpu_flags_i (fpu_flags),
        .busy_o      (busy),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    initial begin
        p0         = 110'h0123_4567_89AB_CDEF_5555_AAAA;
        p1         = 110'h2BAD_F00D_DEAD_BEEF_1234_5678;
        pld        = {p1, p0};
        rst        = 1'b1;
        req        = '0;
        fpu_gnt    = 1'b0;
        fpu_rvalid = 1'b0;
        fpu_result = '0;
        fpu_flags  = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_fpu_req", 32'(fpu_req), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_rr_ptr", 32'(dut.rr_ptr_q), 32'h0);

        // Single requester issue and result
        req     = 2'b01;
        fpu_gnt = 1'b1;
        #1;
        chk("single_fpu_req", 32'(fpu_req), 32'h1);
        chk("single_gnt", 32'(gnt), 32'h1);
        chk("single_pld_lo", fpu_pld[31:0], p0[31:0]);
        chk("single_pld_hi", fpu_pld[109:78], p0[109:78]);
        tick();
        req     = 2'b00;
        fpu_gnt = 1'b0;
        #1;
        chk("single_gnt_once", 32'(gnt), 32'h0);
        chk("single_busy", 32'(busy), 32'h1);
        chk("single_rr_ptr", 32'(dut.rr_ptr_q), 32'h1);
        tick();
        fpu_rvalid = 1'b1;
        fpu_result = 32'h3F80_0000;
        fpu_flags  = 5'h00;
        #1;
        chk("single_rvalid", 32'(rvalid), 32'h1);
        chk("single_result", result, 32'h3F80_0000);
        chk("single_flags", 32'(flags), 32'h0);
        tick();
        fpu_rvalid = 1'b0;
        #1;
        chk("single_busy_clr", 32'(busy), 32'h0);
        chk("single_rvalid_clr", 32'(rvalid), 32'h0);

        // Round robin from rr_ptr=1, filling the FIFO (wraps write index past 3)
        req     = 2'b11;
        fpu_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rr_gnt%0d", i), 32'(gnt), (i % 2 == 0) ? 32'h2 : 32'h1);
            if (i % 2 == 0) chk($sformatf("rr_pld%0d", i), fpu_pld[31:0], p1[31:0]);
            tick();
        end
        // Full: issue blocked even with a pop this cycle
        fpu_rvalid = 1'b1;
        fpu_result = 32'h4000_0000;
        fpu_flags  = 5'h1F;
        #1;
        chk("full_cnt", 32'(dut.cnt_q), 32'h4);
        chk("full_fpu_req", 32'(fpu_req), 32'h0);
        chk("full_gnt", 32'(gnt), 32'h0);
        chk("full_rvalid", 32'(rvalid), 32'h2);
        chk("full_flags", 32'(flags), 32'h1F);
        tick();
        // Unblocked: push (win 1) and pop (tag 0) at count 3
        fpu_flags = 5'h00;
        #1;
        chk("unfull_fpu_req", 32'(fpu_req), 32'h1);
        chk("unfull_gnt", 32'(gnt), 32'h2);
        chk("unfull_rvalid", 32'(rvalid), 32'h1);
        tick();
        req     = 2'b00;
        fpu_gnt = 1'b0;
        #1;
        chk("pp3_cnt", 32'(dut.cnt_q), 32'h3);
        chk("pop_rvalid", 32'(rvalid), 32'h2);
        tick();
        // Simultaneous push/pop at count 2
        req     = 2'b01;
        fpu_gnt = 1'b1;
        #1;
        chk("pp2_cnt_before", 32'(dut.cnt_q), 32'h2);
        chk("pp2_gnt", 32'(gnt), 32'h1);
        chk("pp2_rvalid", 32'(rvalid), 32'h1);
        tick();
        req     = 2'b00;
        fpu_gnt = 1'b0;
        #1;
        chk("pp2_cnt_after", 32'(dut.cnt_q), 32'h2);
        chk("drain0_rvalid", 32'(rvalid), 32'h2);
        tick();
        #1;
        chk("drain1_rvalid", 32'(rvalid), 32'h1);
        tick();
        fpu_rvalid = 1'b0;
        #1;
        chk("drain_busy", 32'(busy), 32'h0);
        chk("drain_rr_ptr", 32'(dut.rr_ptr_q), 32'h1);

        // Backpressure on requester 1
        req = 2'b10;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_fpu_req%0d", i), 32'(fpu_req), 32'h1);
            chk($sformatf("bp_gnt%0d", i), 32'(gnt), 32'h0);
            chk($sformatf("bp_pld%0d", i), fpu_pld[109:78], p1[109:78]);
            tick();
            chk($sformatf("bp_rr_ptr%0d", i), 32'(dut.rr_ptr_q), 32'h1);
        end
        fpu_gnt = 1'b1;
        #1;
        chk("bp_gnt_fire", 32'(gnt), 32'h2);
        tick();
        req = 2'b01;
        #1;
        chk("bp_rr_ptr_moved", 32'(dut.rr_ptr_q), 32'h0);
        chk("second_gnt", 32'(gnt), 32'h1);
        tick();

        // Reset with 2 in flight
        req     = 2'b00;
        fpu_gnt = 1'b0;
        #1;
        chk("pre_rst_cnt", 32'(dut.cnt_q), 32'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_cnt", 32'(dut.cnt_q), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_err", 32'(err), 32'h0);
        chk("mid_rst_rr_ptr", 32'(dut.rr_ptr_q), 32'h0);

        // Stale result with empty FIFO
        fpu_rvalid = 1'b1;
        #1;
        chk("empty_rvalid", 32'(rvalid), 32'h0);
        tick();
        fpu_rvalid = 1'b0;
        #1;
        chk("empty_err", 32'(err), 32'h1);
        tick();
        tick();
        chk("err_sticky", 32'(err), 32'h1);
        chk("err_busy", 32'(busy), 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("err_cleared", 32'(err), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
